// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
// Grant vectors use bit 0 for the data bus and bit 1 for the fetch bus.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam int PRIO_RR   = 0;
    localparam int PRIO_DATA = 1;

    localparam int GNT_DATA  = 0;
    localparam int GNT_INSTR = 1;

    // Wide enough for the largest WAIT preload (RAM_LATENCY-1 = 3).
    localparam int CNT_W = 2;

    localparam logic [3:0] MASK_ALL = 4'hF;

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Two-way round-robin picker: a tie goes to the side not granted last.
// The pointer only moves when the owning FSM actually accepts a grant.
module rr_arbiter2
    import mem_bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 0: the data side wins a tie, 1: the fetch side wins a tie
    logic ptr_q;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            ptr_q <= grant[GNT_DATA];
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port synchronous RAM between the CPU fetch and data buses.
// Each access runs IDLE -> ACCESS -> WAIT (optional) -> RESP with a one-cycle ready pulse.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ARB_IDLE   | waiting for a request; winner's address/data captured here
//  ARB_ACCESS | ramEn strobed for exactly one cycle
//  ARB_WAIT   | RAM read latency beyond one cycle, timed by down-counter
//  ARB_RESP   | owner's ready pulses, read data passed straight through
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int RAM_AW      = 10,
    parameter int RAM_LATENCY = 1,
    parameter int PRIO_MODE   = PRIO_RR
) (
    input  logic              sysClk,
    input  logic              sysRes,
    input  logic              instrReq,
    input  logic [ADDR_W-1:0] instrAddr,
    output logic [31:0]       instrData,
    output logic              instrReady,
    input  logic              dataReq,
    input  logic              dataWe,
    input  logic [3:0]        dataMask,
    input  logic [ADDR_W-1:0] dataAddr,
    input  logic [31:0]       dataWrData,
    output logic [31:0]       dataRdData,
    output logic              dataReady,
    output logic              ramEn,
    output logic              ramWe,
    output logic [3:0]        ramMask,
    output logic [RAM_AW-1:0] ramAddr,
    output logic [31:0]       ramWrData,
    input  logic [31:0]       ramRdData
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RAM_LATENCY - 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_t            owner_q;
    logic              ram_we_q;
    logic [3:0]        ram_mask_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;

    logic [1:0]        rr_grant;
    logic              grab;
    logic              pick_data;

    assign grab = (state_q == ARB_IDLE) && (instrReq || dataReq);

    rr_arbiter2 u_rr (
        .clk     (sysClk),
        .rst     (sysRes),
        .req     ({instrReq, dataReq}),
        .advance (grab),
        .grant   (rr_grant)
    );

    always_comb begin
        pick_data = rr_grant[GNT_DATA];
        if (PRIO_MODE == PRIO_DATA) begin
            pick_data = dataReq;
        end
    end

    always_ff @(posedge sysClk) begin
        if (sysRes) begin
            state_q     <= ARB_IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_DATA;
            ram_we_q    <= 1'b0;
            ram_mask_q  <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grab) begin
                if (pick_data) begin
                    owner_q     <= OWN_DATA;
                    ram_we_q    <= dataWe;
                    ram_mask_q  <= dataMask;
                    ram_addr_q  <= dataAddr[RAM_AW+1:2];
                    ram_wdata_q <= dataWrData;
                end else begin
                    owner_q     <= OWN_INSTR;
                    ram_we_q    <= 1'b0;
                    ram_mask_q  <= MASK_ALL;
                    ram_addr_q  <= instrAddr[RAM_AW+1:2];
                    ram_wdata_q <= '0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (instrReq || dataReq) begin
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (RAM_LATENCY == 1) begin
                    state_d = ARB_RESP;
                end else begin
                    state_d = ARB_WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ARB_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign ramEn      = (state_q == ARB_ACCESS);
    assign ramWe      = ramEn && ram_we_q;
    assign ramMask    = ram_mask_q;
    assign ramAddr    = ram_addr_q;
    assign ramWrData  = ram_wdata_q;

    assign instrReady = (state_q == ARB_RESP) && (owner_q == OWN_INSTR);
    assign dataReady  = (state_q == ARB_RESP) && (owner_q == OWN_DATA);
    assign instrData  = ramRdData;
    assign dataRdData = ramRdData;

    // Byte offset and bits above the RAM window are dropped, so addresses wrap.
    logic unused_bits;
    assign unused_bits = ^{instrAddr[ADDR_W-1:RAM_AW+2], instrAddr[1:0],
                           dataAddr[ADDR_W-1:RAM_AW+2], dataAddr[1:0],
                           rr_grant[GNT_INSTR]};

endmodule
